// File: rtl/alert_ping_sched.sv
// alert_ping_sched
// ----------------
// Ping scheduler for a bank of NAlerts alert receivers. It waits a
// pseudo-random interval, then picks one enabled channel at random and
// holds that receiver's ping request high. The request ends when the
// receiver answers or when the timeout expires. A timeout is reported as a
// one-cycle failure pulse together with the channel index.
//
// Handshake: ping_req_o[i] is a level request. It stays high until the
// scheduler sees ping_ok_i[i] in a Ping cycle, the timeout expires, the
// channel is disabled, or scheduling is switched off. The request always
// drops for at least MinWait cycles, so every new request presents a fresh
// rising edge to its receiver. ping_ok_i bits for any other channel are
// ignored.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   en_i           scheduling enable; low forces Idle on the next cycle
//   alert_en_i     per-channel ping enable
//   timeout_cyc_i  ping response timeout, in cycles
//   ping_ok_i      per-receiver ping response pulse
//   ping_req_o     per-receiver ping request, at most one bit high
//   ping_done_o    one-cycle pulse on a successful ping
//   ping_fail_o    one-cycle pulse on a ping timeout
//   ping_fail_id_o channel of the last failure, held until the next one
//   busy_o         high whenever the scheduler is not Idle
module alert_ping_sched #(
    parameter int          NAlerts  = 4,
    parameter int          IdW      = $clog2(NAlerts),
    parameter int          WaitBits = 8,
    parameter int          MinWait  = 16,
    parameter int          TimeoutW = 16,
    parameter logic [15:0] LfsrSeed = 16'hACE1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [NAlerts-1:0]  alert_en_i,
    input  logic [TimeoutW-1:0] timeout_cyc_i,
    input  logic [NAlerts-1:0]  ping_ok_i,
    output logic [NAlerts-1:0]  ping_req_o,
    output logic                ping_done_o,
    output logic                ping_fail_o,
    output logic [IdW-1:0]      ping_fail_id_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PING = 2'd2
    } state_e;

    state_e              r_state;
    logic [15:0]         r_lfsr;
    logic [WaitBits:0]   r_wait_cnt;
    logic [TimeoutW-1:0] r_tmo_cnt;
    logic [IdW-1:0]      r_id;
    logic [NAlerts-1:0]  r_ping_req;
    logic                r_done;
    logic                r_fail;
    logic [IdW-1:0]      r_fail_id;

    logic [15:0]         w_lfsr_next;
    logic [WaitBits:0]   w_wait_load;
    logic [IdW-1:0]      w_cand;
    logic [NAlerts-1:0]  w_cand_onehot;

    // Galois LFSR, shifting right, taps 0xB400 (maximal length).
    assign w_lfsr_next   = (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    // One extra bit of width so the random part plus MinWait cannot wrap.
    assign w_wait_load   = {1'b0, w_lfsr_next[WaitBits-1:0]} + (WaitBits+1)'(MinWait);
    // The candidate comes from LFSR bits above the wait field, so the channel
    // choice is not tied to the length of the wait just finished.
    assign w_cand        = r_lfsr[IdW+7:8];
    assign w_cand_onehot = NAlerts'(1) << w_cand;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_lfsr     <= LfsrSeed;
            r_wait_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_id       <= '0;
            r_ping_req <= '0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            r_fail_id  <= '0;
        end else begin
            r_done <= 1'b0;
            r_fail <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (en_i) begin
                        r_lfsr     <= w_lfsr_next;
                        r_wait_cnt <= w_wait_load;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!en_i) begin
                        r_state <= ST_IDLE;
                    end else if (r_wait_cnt <= (WaitBits+1)'(1)) begin
                        if (alert_en_i[w_cand]) begin
                            r_id       <= w_cand;
                            r_tmo_cnt  <= '0;
                            r_ping_req <= w_cand_onehot;
                            r_state    <= ST_PING;
                        end else begin
                            // Disabled candidate: skip it and draw a new wait.
                            r_lfsr     <= w_lfsr_next;
                            r_wait_cnt <= w_wait_load;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - (WaitBits+1)'(1);
                    end
                end
                ST_PING: begin
                    if (!en_i) begin
                        r_ping_req <= '0;
                        r_state    <= ST_IDLE;
                    end else if (ping_ok_i[r_id] || !alert_en_i[r_id] ||
                                 (r_tmo_cnt == timeout_cyc_i)) begin
                        // Response beats a same-cycle timeout; a channel
                        // disabled mid-ping ends quietly.
                        r_done     <= ping_ok_i[r_id];
                        r_fail     <= !ping_ok_i[r_id] && alert_en_i[r_id];
                        if (!ping_ok_i[r_id] && alert_en_i[r_id]) begin
                            r_fail_id <= r_id;
                        end
                        r_ping_req <= '0;
                        r_lfsr     <= w_lfsr_next;
                        r_wait_cnt <= w_wait_load;
                        r_state    <= ST_WAIT;
                    end else if (r_tmo_cnt != '1) begin
                        r_tmo_cnt <= r_tmo_cnt + TimeoutW'(1);
                    end
                end
                default: begin
                    r_ping_req <= '0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign ping_req_o     = r_ping_req;
    assign ping_done_o    = r_done;
    assign ping_fail_o    = r_fail;
    assign ping_fail_id_o = r_fail_id;
    assign busy_o         = (r_state != ST_IDLE);

endmodule

// File: doc/alert_ping_sched.md
Name: alert_ping_sched

Overview:
- Ping scheduler for a bank of NAlerts alert receivers, one per alert source.
- Waits a pseudo-random interval, then picks one enabled alert channel at random and holds its ping request high until that receiver reports a ping response or a timeout expires.
- A timeout is reported as a ping failure on a one-cycle pulse with the channel index.
- Sits beside the alert receivers in the alert handler; its outputs drive each receiver's ping request input.

Parameters:
- NAlerts, 4: number of receivers; power of two, 2..32.
- IdW, $clog2(NAlerts): width of the channel index.
- WaitBits, 8: number of LFSR bits used for the random wait.
- MinWait, 16: constant added to the random wait; must be at least 2.
- TimeoutW, 16: width of the timeout counter.
- LfsrSeed, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- en_i  in  1  scheduling enable.
- alert_en_i  in  NAlerts  per-channel ping enable.
- timeout_cyc_i  in  TimeoutW  ping response timeout, in cycles.
- ping_ok_i  in  NAlerts  per-receiver ping response pulse.
- ping_req_o  out  NAlerts  per-receiver ping request; at most one bit high at a time.
- ping_done_o  out  1  one-cycle pulse on a successful ping.
- ping_fail_o  out  1  one-cycle pulse on a ping timeout.
- ping_fail_id_o  out  IdW  channel index of the last failure; held until the next failure.
- busy_o  out  1  high when the state is not Idle.

Behaviour:
- Reset values:
  - state = Idle; lfsr_q = LfsrSeed.
  - All counters = 0; id_q = 0.
  - All outputs 0.
- LFSR: 16-bit Galois, shifting right.
  - next = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 0).
  - Advances only on entry into Wait.
- Idle:
  - Stays in Idle while en_i = 0.
  - When en_i = 1: lfsr_q <= next, wait_cnt <= next[WaitBits-1:0] + MinWait (computed at WaitBits+1 width, no overflow), go to Wait.
- Wait:
  - Decrements wait_cnt every cycle.
  - Leaves Wait when wait_cnt == 1, so W = load value gives exactly W cycles in Wait.
  - Candidate channel = lfsr_q[IdW+7:8].
  - If alert_en_i[candidate] = 1: id_q <= candidate, tmo_cnt <= 0, go to Ping.
  - Otherwise (skip): re-enter Wait; this advances the LFSR and loads a new wait count.
- Ping:
  - ping_req_o = one-hot(id_q), driven from registered state only, no combinational path from any input.
  - tmo_cnt increments every cycle, saturating at all-ones.
  - ping_ok_i[id_q] = 1: pulse ping_done_o, re-enter Wait.
  - Else if tmo_cnt == timeout_cyc_i: pulse ping_fail_o, set ping_fail_id_o <= id_q, re-enter Wait.
  - If both conditions hold in the same cycle, ping_ok_i wins and no failure is reported.
  - timeout_cyc_i = 0: the first Ping cycle fails unless ping_ok_i arrives in that same cycle.
  - ping_ok_i on channels other than id_q is ignored in every state.
- Abort cases:
  - en_i = 0 in any state: go to Idle next cycle; no done/fail pulse; the request drops the next cycle.
  - alert_en_i[id_q] falls during Ping: re-enter Wait, no fail pulse.
- Request gap: MinWait ≥ 2 guarantees ping_req_o is low for at least two cycles between requests, so every request presents a fresh rising edge to its receiver.
- timeout_cyc_i is sampled every cycle; software changes it only while en_i = 0.
- Reset mid-Ping: ping_req_o drops asynchronously and the LFSR returns to LfsrSeed.

Test Plan:
- Default parameters, all alert_en_i = 1, timeout 100, en_i rising at cycle t:
  - LFSR steps 0xACE1 → 0xE270; wait = 0x70 + 16 = 128.
  - ping_req_o = 4'b0100 from cycle t+129.
  - ping_ok_i[2] three cycles later → ping_done_o pulses once and ping_req_o = 0 on the next cycle.
- Same setup, no response:
  - ping_req_o[2] stays high for 101 cycles.
  - ping_fail_o pulses once, ping_fail_id_o = 2, then a new Wait starts from LFSR 0x7138.
- alert_en_i = 4'b1011:
  - Channel 2 is skipped; no request is raised at t+129.
  - The LFSR advances to 0x7138 and a new 72-cycle (0x38 + 16) Wait starts.
  - At its end the candidate is channel 1 (0x7138[9:8] = 1) and ping_req_o = 4'b0010.
- ping_ok_i[2] in the same cycle that tmo_cnt reaches timeout_cyc_i → ping_done_o = 1 and ping_fail_o = 0.
- Stray pulses: during Ping on channel 2, pulse ping_ok_i[0] → no done pulse and the request stays high.
- en_i falls during Ping → ping_req_o = 0 next cycle, busy_o = 0, no pulses.
- Reset asserted mid-Ping → all outputs 0 immediately; rerunning the first scenario reproduces the same first request cycle and channel.
